// File: rtl/pulpemu_cam_emu.sv
// pulpemu_cam_emu: synthetic CPI camera source (pclk/vsync/href/data) with frame/line FSM and test patterns.
// Define PULPEMU_CAM_EMU_FRAME_TAG_EN to stamp frame_cnt_o into pixels x=0,1 of line 0.
module pulpemu_cam_emu #(
  parameter int IMG_W        = 320,
  parameter int IMG_H        = 240,
  parameter int HBLANK       = 16,
  parameter int VSYNC_LINES  = 2,
  parameter int VBLANK_LINES = 4,
  parameter int PCLK_DIV     = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic [1:0]  pattern_sel_i,
  output logic        cam_pclk_o,
  output logic        cam_vsync_o,
  output logic        cam_hsync_o,
  output logic [7:0]  cam_data_o,
  output logic [15:0] frame_cnt_o,
  output logic        busy_o
);
  localparam int LINE = IMG_W + HBLANK;
  localparam int DW = PCLK_DIV > 2 ? $clog2(PCLK_DIV) : 1;
  typedef enum logic [1:0] {IDLE, VSYNC, VBLANK, ACTIVE} state_t;
  state_t state, state_d;
  logic [DW-1:0] div_cnt, div_d;
  logic [15:0] x, y, x_d, y_d, fc_d;
  logic [1:0] pat, pat_d;
  logic [7:0] pix;
  logic tick, line_end, last_line, act_d;
  assign tick = div_cnt == DW'(PCLK_DIV - 1);
  assign div_d = tick ? '0 : div_cnt + 1'b1;
  assign line_end = x == 16'(LINE - 1);
  assign last_line = (state == VSYNC  && y == 16'(VSYNC_LINES - 1))  ||
                     (state == VBLANK && y == 16'(VBLANK_LINES - 1)) ||
                     (state == ACTIVE && y == 16'(IMG_H - 1));
  assign busy_o = state != IDLE;
  always_comb begin
    state_d = state;
    x_d = x;
    y_d = y;
    pat_d = pat;
    fc_d = frame_cnt_o;
    if (tick) begin
      if (state == IDLE) begin
        if (en_i) begin
          state_d = VSYNC;
          pat_d = pattern_sel_i;
          x_d = '0;
          y_d = '0;
        end
      end else begin
        x_d = line_end ? '0 : x + 16'd1;
        if (line_end) begin
          y_d = last_line ? '0 : y + 16'd1;
          if (last_line) begin
            case (state)
              VSYNC:  state_d = VBLANK;
              VBLANK: state_d = ACTIVE;
              ACTIVE: begin
                fc_d = frame_cnt_o + 16'd1;
                state_d = en_i ? VSYNC : IDLE;
                pat_d = en_i ? pattern_sel_i : pat;
              end
              default: state_d = IDLE;
            endcase
          end
        end
      end
    end
  end
  // Outputs are computed from the post-tick position so they land in the same flop update as the FSM.
  always_comb begin
    pix = pat_d == 2'd0 ? x_d[7:0] :
          pat_d == 2'd1 ? y_d[7:0] :
          pat_d == 2'd2 ? {8{x_d[3] ^ y_d[3]}} :
                          x_d[7:0] + y_d[7:0] + fc_d[7:0];
`ifdef PULPEMU_CAM_EMU_FRAME_TAG_EN
    if (y_d == 16'd0 && x_d < 16'd2) pix = x_d[0] ? fc_d[7:0] : fc_d[15:8];
`endif
  end
  assign act_d = state_d == ACTIVE && x_d < 16'(IMG_W);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_cnt <= '0;
      cam_pclk_o <= 1'b0;
      state <= IDLE;
      x <= '0;
      y <= '0;
      pat <= '0;
      frame_cnt_o <= '0;
      cam_vsync_o <= 1'b0;
      cam_hsync_o <= 1'b0;
      cam_data_o <= '0;
    end else begin
      div_cnt <= div_d;
      cam_pclk_o <= div_d >= DW'(PCLK_DIV / 2);
      state <= state_d;
      x <= x_d;
      y <= y_d;
      pat <= pat_d;
      frame_cnt_o <= fc_d;
      if (tick) begin
        cam_vsync_o <= state_d == VSYNC;
        cam_hsync_o <= act_d;
        cam_data_o <= act_d ? pix : 8'h00;
      end
    end
  end
endmodule

// File: tb/tb_pulpemu_cam_emu.sv
// tb_pulpemu_cam_emu: directed vectors for the CPI camera emulator (8x4 frame, 1+1 sync/blank lines, pclk/4).
module tb_pulpemu_cam_emu;
  localparam int W = 8, H = 4, HB = 2, VL = 1, BL = 1, DIV = 4;
  localparam int LINE = W + HB;
  localparam int FR = (VL + BL + H) * LINE;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic [1:0] sel = 2'd0;
  logic pclk, vs, hs, busy;
  logic [7:0] data;
  logic [15:0] fc;
  logic pclk2, vs2, hs2, busy2;
  logic [7:0] data2;
  logic [15:0] fc2;
  int checks = 0, errors = 0;
  logic fv[FR], fh[FR];
  logic [7:0] fd[FR];
  logic [7:0] d2[16];
  logic pre_hs;
  logic [15:0] fc_end;
  typedef struct {logic [1:0] sel; int x; int y; logic [7:0] d; logic h;} vec_t;
  vec_t tbl[10];

  pulpemu_cam_emu #(.IMG_W(W), .IMG_H(H), .HBLANK(HB), .VSYNC_LINES(VL), .VBLANK_LINES(BL), .PCLK_DIV(DIV)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .pattern_sel_i(sel),
    .cam_pclk_o(pclk), .cam_vsync_o(vs), .cam_hsync_o(hs), .cam_data_o(data),
    .frame_cnt_o(fc), .busy_o(busy));

  pulpemu_cam_emu #(.IMG_W(16), .IMG_H(H), .HBLANK(HB), .VSYNC_LINES(VL), .VBLANK_LINES(BL), .PCLK_DIV(DIV)) dut16 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(1'b1), .pattern_sel_i(2'd2),
    .cam_pclk_o(pclk2), .cam_vsync_o(vs2), .cam_hsync_o(hs2), .cam_data_o(data2),
    .frame_cnt_o(fc2), .busy_o(busy2));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic next_px();
    int n = 0;
    while (pclk && n < 20) begin @(posedge clk); #1; n++; end
    while (!pclk && n < 20) begin @(posedge clk); #1; n++; end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL pclk_timeout: got no rising edge in 20 clk, expected one");
    end
  endtask

  function automatic int idx(input int x, input int y);
    return (VL + BL) * LINE + y * LINE + x;
  endfunction

  task automatic capture(input int chg_at, input logic chg_en, input logic [1:0] chg_sel);
    int k = 0, nv = 0, nh = 0, nb = 0, f1 = -1;
    pre_hs = 1'b0;
    do begin
      next_px();
      if (hs) pre_hs = 1'b1;
      k++;
    end while (!vs && k < 400);
    chk("capture_sync_vsync", vs, 1);
    fv[0] = vs; fh[0] = hs; fd[0] = data;
    for (int i = 1; i < FR; i++) begin
      if (i == chg_at) begin en = chg_en; sel = chg_sel; end
      next_px();
      fv[i] = vs; fh[i] = hs; fd[i] = data;
    end
    fc_end = fc;
    for (int i = 0; i < FR; i++) begin
      if (fv[i]) nv++;
      if (fh[i]) nh++;
      if (fv[i] && fh[i]) nb++;
      if (fh[i] && f1 < 0) f1 = i;
    end
    chk("vsync_ticks", nv, VL * LINE);
    chk("vsync_run_end", {fv[VL * LINE - 1], fv[VL * LINE]}, 2'b10);
    chk("hsync_ticks", nh, W * H);
    chk("vsync_hsync_overlap", nb, 0);
    chk("first_hsync_tick", f1, (VL + BL) * LINE);
  endtask

  initial begin
    int n;
    tbl = '{
      '{2'd0, 7, 3, 8'h07, 1'b1},
      '{2'd0, 9, 2, 8'h00, 1'b0},
      '{2'd1, 5, 2, 8'h02, 1'b1},
      '{2'd1, 0, 3, 8'h03, 1'b1},
      '{2'd2, 7, 3, 8'h00, 1'b1},
      '{2'd2, 3, 1, 8'h00, 1'b1},
      '{2'd3, 2, 1, 8'h0A, 1'b1},
      '{2'd3, 7, 3, 8'h12, 1'b1},
      '{2'd0, 4, 1, 8'h04, 1'b1},
      '{2'd3, 8, 3, 8'h00, 1'b0}
    };
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pclk", pclk, 0);
    chk("rst_vsync", vs, 0);
    chk("rst_hsync", hs, 0);
    chk("rst_data", data, 0);
    chk("rst_frame_cnt", fc, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    en = 1'b1;
    sel = 2'd0;
    n = 0;
    while (!vs && n < 50) begin @(posedge clk); #1; n++; end
    chk("en_to_vsync_within_5clk", n <= DIV + 1 && n > 0, 1);
    n = 0;
    while (fc != 16'd1 && n < 1000) begin @(posedge clk); #1; n++; end
    chk("frame_period_clk", n, 240);
    for (int i = 0; i < 10; i++) begin
      sel = tbl[i].sel;
      capture(-1, 1'b1, tbl[i].sel);
      chk($sformatf("tbl%0d_data", i), fd[idx(tbl[i].x, tbl[i].y)], tbl[i].d);
      chk($sformatf("tbl%0d_hsync", i), fh[idx(tbl[i].x, tbl[i].y)], tbl[i].h);
      chk($sformatf("tbl%0d_frame_cnt", i), fc_end, i + 1);
      chk($sformatf("tbl%0d_busy", i), busy, 1);
    end
    n = 0;
    do begin next_px(); n++; end while (!vs && n < 400);
    repeat (idx(3, 2)) next_px();
    chk("pre_reset_hsync", hs, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_pclk", pclk, 0);
    chk("midrst_vsync", vs, 0);
    chk("midrst_hsync", hs, 0);
    chk("midrst_data", data, 0);
    chk("midrst_frame_cnt", fc, 0);
    chk("midrst_busy", busy, 0);
    sel = 2'd1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    capture(30, 1'b1, 2'd3);
    chk("restart_no_hsync_before_vsync", pre_hs, 0);
    chk("restart_frame_cnt", fc_end, 0);
    for (int y = 0; y < H; y++) chk($sformatf("midchg_line%0d_data", y), fd[idx(3, y)], y);
    capture(-1, 1'b1, 2'd3);
`ifdef PULPEMU_CAM_EMU_FRAME_TAG_EN
    chk("f1_tag_hi", fd[idx(0, 0)], 8'h00);
    chk("f1_tag_lo", fd[idx(1, 0)], 8'h01);
`else
    chk("f1_pat3_px00", fd[idx(0, 0)], 8'h01);
`endif
    chk("f1_pat3_px20", fd[idx(2, 0)], 8'h03);
    capture(-1, 1'b1, 2'd3);
`ifdef PULPEMU_CAM_EMU_FRAME_TAG_EN
    chk("f2_tag_hi", fd[idx(0, 0)], 8'h00);
    chk("f2_tag_lo", fd[idx(1, 0)], 8'h02);
`else
    chk("f2_pat3_px00", fd[idx(0, 0)], 8'h02);
    chk("f2_pat3_px10", fd[idx(1, 0)], 8'h03);
`endif
    chk("f2_pat3_px20", fd[idx(2, 0)], 8'h04);
    capture(idx(3, 1), 1'b0, 2'd3);
    chk("endrop_frame_cnt_during", fc_end, 3);
    chk("endrop_last_line_data", fd[idx(6, 3)], 8'h0C);
    repeat (20) @(posedge clk);
    #1;
    chk("endrop_frame_cnt_after", fc, 4);
    chk("endrop_busy", busy, 0);
    chk("endrop_outputs_low", {vs, hs, data}, 0);
    repeat (100) @(posedge clk);
    #1;
    chk("idle_hold_low", {busy, vs, hs, data}, 0);
    chk("idle_hold_frame_cnt", fc, 4);
    n = 0;
    do begin next_px(); n++; end while (!hs2 && n < 300);
    chk("w16_found_hsync", hs2, 1);
    chk("w16_pclk_lockstep", pclk2, pclk);
    chk("w16_busy", busy2, 1);
    d2[0] = data2;
    for (int k = 1; k < 16; k++) begin next_px(); d2[k] = data2; end
    chk("w16_hsync_x15", hs2, 1);
    chk("w16_vsync_low", vs2, 0);
    chk("w16_px0", d2[0], 8'h00);
    chk("w16_px7", d2[7], 8'h00);
    chk("w16_px8", d2[8], 8'hFF);
    chk("w16_px15", d2[15], 8'hFF);
    next_px();
    chk("w16_blank_hsync", hs2, 0);
    chk("w16_blank_data", data2, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
